// File: rtl/mtime_bus_initiator_pkg.sv
// mtime_bus_initiator_pkg: shared encodings for the machine-timer bus initiator
package mtime_bus_initiator_pkg;
  localparam int TIMER_W = 48;
  localparam logic [1:0] OP_RD_MTIME    = 2'd0;
  localparam logic [1:0] OP_RD_MTIMECMP = 2'd1;
  localparam logic [1:0] OP_WR_MTIMECMP = 2'd2;
  localparam logic [31:0] OFF_MTIME_LO    = 32'h0;
  localparam logic [31:0] OFF_MTIME_HI    = 32'h4;
  localparam logic [31:0] OFF_MTIMECMP_LO = 32'h8;
  localparam logic [31:0] OFF_MTIMECMP_HI = 32'hC;
  typedef enum logic [2:0] {
    IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO_MAX, WR_HI, WR_LO, RESP
  } state_e;
endpackage

// File: rtl/mtime_bus_initiator.sv
// mtime_bus_initiator: tear-free 48-bit mtime/mtimecmp reads and glitch-free mtimecmp writes
module mtime_bus_initiator
  import mtime_bus_initiator_pkg::*;
#(
  parameter logic [31:0] TIMER_BASE_ADDR = 32'h40002000,
  parameter int          MAX_RETRIES     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [TIMER_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [TIMER_W-1:0] rsp_rdata,
  output logic               rsp_error,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [31:0]        mem_rdata
);
  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [TIMER_W-1:0] wdata_q, wdata_d;
  logic [15:0]        hi1_q, hi1_d;
  logic [31:0]        lo_q, lo_d;
  logic [2:0]         retry_q, retry_d;
  logic [TIMER_W-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [15:0]        hi_in;
  logic [31:0]        lo_off, hi_off;
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign hi_in     = mem_rdata[15:0];
  assign lo_off    = (op_q == OP_RD_MTIME) ? OFF_MTIME_LO : OFF_MTIMECMP_LO;
  assign hi_off    = (op_q == OP_RD_MTIME) ? OFF_MTIME_HI : OFF_MTIMECMP_HI;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    hi1_d   = hi1_q;
    lo_d    = lo_q;
    retry_d = retry_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        wdata_d = cmd_wdata;
        retry_d = 3'd0;
        state_d = (cmd_op == OP_WR_MTIMECMP) ? WR_LO_MAX :
                  (cmd_op == OP_RD_MTIME || cmd_op == OP_RD_MTIMECMP) ? RD_HI1 : RESP;
        if (cmd_op == 2'd3) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RD_HI1: begin
        hi1_d   = hi_in;
        state_d = RD_LO;
      end
      RD_LO: begin
        lo_d    = mem_rdata;
        state_d = RD_HI2;
      end
      RD_HI2: begin
        // A changed hi half means lo may have wrapped between reads; re-read lo against the newer hi.
        if (hi_in == hi1_q) begin
          rdata_d = {hi1_q, lo_q};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (retry_q == 3'(MAX_RETRIES)) begin
          rdata_d = {hi_in, lo_q};
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          hi1_d   = hi_in;
          retry_d = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
          state_d = RD_LO;
        end
      end
      WR_LO_MAX: state_d = WR_HI;
      WR_HI:     state_d = WR_LO;
      WR_LO: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  // Parking lo at all-ones first keeps mtimecmp above mtime while hi is being changed.
  always_comb begin
    mem_re    = state_q inside {RD_HI1, RD_LO, RD_HI2};
    mem_we    = state_q inside {WR_LO_MAX, WR_HI, WR_LO};
    mem_addr  = (state_q == RD_HI1 || state_q == RD_HI2) ? TIMER_BASE_ADDR + hi_off :
                (state_q == RD_LO)                       ? TIMER_BASE_ADDR + lo_off :
                (state_q == WR_HI)                       ? TIMER_BASE_ADDR + OFF_MTIMECMP_HI :
                (state_q == WR_LO_MAX || state_q == WR_LO) ? TIMER_BASE_ADDR + OFF_MTIMECMP_LO : 32'h0;
    mem_wdata = (state_q == WR_LO_MAX) ? 32'hFFFF_FFFF :
                (state_q == WR_HI)     ? {16'h0, wdata_q[47:32]} :
                (state_q == WR_LO)     ? wdata_q[31:0] : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      wdata_q <= '0;
      hi1_q   <= '0;
      lo_q    <= '0;
      retry_q <= 3'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      hi1_q   <= hi1_d;
      lo_q    <= lo_d;
      retry_q <= retry_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mtime_bus_initiator.sv
// tb_mtime_bus_initiator: scoreboard bench with a machine-timer peripheral model
module tb_mtime_bus_initiator;
  localparam logic [31:0] BASE = 32'h40002000;
  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } bus_t;
  typedef struct { logic [47:0] d; logic e; int lat; } rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_error, mem_we, mem_re;
  logic [1:0] cmd_op;
  logic [47:0] cmd_wdata, rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [47:0] mtime, mtimecmp, mt_val, cmp_val;
  logic [15:0] hcnt;
  logic run, hostile, mt_ld, cmp_ld, irq, irq_win, irq_seen;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t b_exp;
  rsp_t r_exp;
  int vecs = 0, miss = 0, cyc = 0, acc_cyc = 0, accepts = 0;
  always #5 clk = ~clk;
  mtime_bus_initiator dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );
  assign irq = mtime >= mtimecmp;
  // Timer peripheral: hostile mode makes every hi read return a fresh value.
  always @(posedge clk) begin
    if (mt_ld) begin
      mtime <= mt_val;
      hcnt  <= mt_val[47:32];
    end else begin
      if (run) mtime <= mtime + 48'd1;
      if (mem_re && mem_addr[2]) hcnt <= hcnt + 16'd1;
    end
    if (cmp_ld) mtimecmp <= cmp_val;
    else if (mem_we && mem_addr == BASE + 32'h8) mtimecmp[31:0] <= mem_wdata;
    else if (mem_we && mem_addr == BASE + 32'hC) mtimecmp[47:32] <= mem_wdata[15:0];
  end
  always @* begin
    mem_rdata = 32'h0;
    case (mem_addr)
      BASE:         mem_rdata = mtime[31:0];
      BASE + 32'h4: mem_rdata = {16'hDEAD, hostile ? hcnt : mtime[47:32]};
      BASE + 32'h8: mem_rdata = mtimecmp[31:0];
      BASE + 32'hC: mem_rdata = {16'hBEEF, hostile ? hcnt : mtimecmp[47:32]};
      default:      mem_rdata = 32'h0;
    endcase
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      accepts++;
      acc_cyc = cyc;
    end
    cyc++;
  end
  // Monitor: compares every bus transfer and every response against the queues.
  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      chk("we_re_exclusive", 64'(mem_we && mem_re), 64'd0);
      if (bus_q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL bus_unexpected: got we=%b addr=%h wdata=%h, expected no transfer", mem_we, mem_addr, mem_wdata);
      end else begin
        b_exp = bus_q.pop_front();
        chk("bus_we", 64'(mem_we), 64'(b_exp.we));
        chk("bus_addr", 64'(mem_addr), 64'(b_exp.a));
        if (b_exp.we) chk("bus_wdata", 64'(mem_wdata), 64'(b_exp.d));
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, expected no response", rsp_rdata, rsp_error);
      end else begin
        r_exp = rsp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(r_exp.d));
        chk("rsp_error", 64'(rsp_error), 64'(r_exp.e));
        chk("rsp_latency", 64'(cyc - acc_cyc), 64'(r_exp.lat));
      end
    end
    if (irq_win && irq) irq_seen = 1'b1;
  end
  task automatic push_bus(input logic we, input logic [31:0] off, input logic [31:0] d);
    bus_q.push_back('{we: we, a: BASE + off, d: d});
  endtask
  task automatic push_rd(input logic [31:0] lo_off);
    push_bus(1'b0, lo_off + 32'h4, 32'h0);
    push_bus(1'b0, lo_off, 32'h0);
    push_bus(1'b0, lo_off + 32'h4, 32'h0);
  endtask
  task automatic push_rsp(input logic [47:0] d, input logic e, input int lat);
    rsp_q.push_back('{d: d, e: e, lat: lat});
  endtask
  // Called at a negedge; pending loads take effect on the accept edge only.
  task automatic issue(input logic [1:0] op, input logic [47:0] wd, input int hold);
    cmd_op = op;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    mt_ld = 1'b0;
    cmp_ld = 1'b0;
    repeat (hold) @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      miss++;
      $display("FAIL %s_timeout: got %0d rsp / %0d bus pending, expected 0 / 0", nm, rsp_q.size(), bus_q.size());
      rsp_q.delete();
      bus_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end
  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = '0;
    run = 1'b0; hostile = 1'b0; irq_win = 1'b0; irq_seen = 1'b0;
    mt_ld = 1'b1; mt_val = '0; cmp_ld = 1'b1; cmp_val = 48'hFFFF_FFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_mem_strobes", 64'({mem_we, mem_re}), 64'd0);
    rst = 1'b0; mt_ld = 1'b0; cmp_ld = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    // Stable read of a held mtime.
    mt_val = 48'h1234_5678_9ABC; mt_ld = 1'b1;
    push_rd(32'h0);
    push_rsp(48'h1234_5678_9ABC, 1'b0, 4);
    issue(2'd0, '0, 0);
    drain("stable_read");
    chk("rdata_held", 64'(rsp_rdata), 64'h1234_5678_9ABC);
    // Rollover of the lo half between the two hi reads.
    mt_val = 48'h0001_FFFF_FFFE; mt_ld = 1'b1; run = 1'b1;
    push_rd(32'h0);
    push_bus(1'b0, 32'h0, 32'h0);
    push_bus(1'b0, 32'h4, 32'h0);
    push_rsp(48'h0002_0000_0001, 1'b0, 6);
    issue(2'd0, '0, 0);
    drain("rollover");
    run = 1'b0;
    // Glitch-free mtimecmp write, then read it back.
    mt_val = 48'h0000_0000_0800; mt_ld = 1'b1;
    cmp_val = 48'h0001_0000_0000; cmp_ld = 1'b1;
    push_bus(1'b1, 32'h8, 32'hFFFF_FFFF);
    push_bus(1'b1, 32'hC, 32'h0000_0000);
    push_bus(1'b1, 32'h8, 32'h0000_1000);
    push_rsp(48'h0, 1'b0, 4);
    irq_seen = 1'b0; irq_win = 1'b1;
    issue(2'd2, 48'h0000_0000_1000, 0);
    drain("write");
    irq_win = 1'b0;
    chk("irq_during_write", 64'(irq_seen), 64'd0);
    chk("mtimecmp_written", 64'(mtimecmp), 64'h0000_0000_1000);
    push_rd(32'h8);
    push_rsp(48'h0000_0000_1000, 1'b0, 4);
    issue(2'd1, '0, 0);
    drain("readback");
    // Hi half changes on every read: retries run out.
    hostile = 1'b1;
    mt_val = 48'h0010_0000_5555; mt_ld = 1'b1;
    push_bus(1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      push_bus(1'b0, 32'h0, 32'h0);
      push_bus(1'b0, 32'h4, 32'h0);
    end
    push_rsp(48'h0014_0000_5555, 1'b1, 10);
    issue(2'd0, '0, 0);
    drain("retry_exhaust");
    hostile = 1'b0;
    // Reserved op: error, no bus activity.
    push_rsp(48'h0, 1'b1, 1);
    issue(2'd3, 48'hFFFF_FFFF_FFFF, 0);
    drain("reserved_op");
    // cmd_valid held through a read is accepted once.
    begin
      int a0;
      a0 = accepts;
      mt_val = 48'hABCD_0000_0001; mt_ld = 1'b1;
      push_rd(32'h0);
      push_rsp(48'hABCD_0000_0001, 1'b0, 4);
      issue(2'd0, '0, 3);
      drain("held_valid");
      chk("single_accept", 64'(accepts - a0), 64'd1);
    end
    // Reset during WR_HI abandons the write.
    push_bus(1'b1, 32'h8, 32'hFFFF_FFFF);
    push_bus(1'b1, 32'hC, 32'h0000_0005);
    issue(2'd2, 48'h0005_0000_0000, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    drain("rst_write");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
